// File: rtl/attn_score_lif_pkg.sv
// Shared hyper-parameters for the attention-score LIF block: time steps,
// partial-sum width derived from the systolic array size, default threshold.
package attn_score_lif_pkg;

    localparam int unsigned TIME_STEPS        = 4;
    localparam int unsigned SYSTOLIC_UNIT_NUM = 16;
    localparam int unsigned SUM_W             = $clog2(2 * SYSTOLIC_UNIT_NUM);
    localparam int unsigned V_TH_DEFAULT      = 8;

    // Accumulator width that cannot wrap for chunk_num full-scale partial sums
    function automatic int unsigned acc_width(input int unsigned chunk_num);
        return SUM_W + $clog2(chunk_num + 1);
    endfunction

endpackage

// File: rtl/attn_score_lif_if.sv
// Partial-sum input / spike output bundle of attn_score_lif.
// o_Attn_score (and the ACC_W parameter) exist only with ATTN_SCORE_OUT_EN.
interface attn_score_lif_if
    import attn_score_lif_pkg::*;
`ifdef ATTN_SCORE_OUT_EN
#(
    parameter int unsigned ACC_W = 7
)
`endif
();

    logic                          i_Calc_valid;
    logic [SUM_W*TIME_STEPS-1:0]   i_Calc_data;
    logic                          i_Clear;
    logic [TIME_STEPS-1:0]         o_Attn_spikes;
    logic                          o_Attn_valid;
    logic                          o_Busy;
`ifdef ATTN_SCORE_OUT_EN
    logic [ACC_W*TIME_STEPS-1:0]   o_Attn_score;
`endif

    modport master (
        output i_Calc_valid, i_Calc_data, i_Clear,
`ifdef ATTN_SCORE_OUT_EN
        input  o_Attn_score,
`endif
        input  o_Attn_spikes, o_Attn_valid, o_Busy
    );

    modport slave (
        input  i_Calc_valid, i_Calc_data, i_Clear,
`ifdef ATTN_SCORE_OUT_EN
        output o_Attn_score,
`endif
        output o_Attn_spikes, o_Attn_valid, o_Busy
    );

endinterface

// File: rtl/attn_score_lif_lif_step_stage.sv
// One registered LIF time step (tau=2, hard reset): integrates X[STEP] into the
// membrane carried from the previous step and sets spike bit STEP.
module attn_score_lif_lif_step_stage #(
    parameter int unsigned ACC_W      = 7,
    parameter int unsigned TIME_STEPS = 4,
    parameter int unsigned STEP       = 0,
    parameter int unsigned V_TH       = 8
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    input  logic                  in_valid,
    input  logic [ACC_W-1:0]      in_v,
    input  logic [ACC_W-1:0]      in_x,
    input  logic [TIME_STEPS-1:0] in_spikes,
    output logic                  out_valid,
    output logic [ACC_W-1:0]      out_v,
    output logic [TIME_STEPS-1:0] out_spikes
);

    logic [ACC_W:0]          h_sum;
    logic [ACC_W-1:0]        h;
    logic                    fire;
    logic                    valid_q, valid_d;
    logic [ACC_W-1:0]        v_q, v_d;
    logic [TIME_STEPS-1:0]   spk_q, spk_d;

    // Sum is one bit wider so the halving never loses the carry
    always_comb begin
        h_sum   = {1'b0, in_v} + {1'b0, in_x};
        h       = ACC_W'(h_sum >> 1);
        fire    = ({1'b0, h} >= (ACC_W + 1)'(V_TH));
        valid_d = in_valid;
        v_d     = v_q;
        spk_d   = spk_q;
        if (in_valid) begin
            v_d         = fire ? '0 : h;
            spk_d       = in_spikes;
            spk_d[STEP] = fire;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            valid_q <= 1'b0;
            v_q     <= '0;
            spk_q   <= '0;
        end else begin
            valid_q <= valid_d;
            v_q     <= v_d;
            spk_q   <= spk_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_v      = v_q;
    assign out_spikes = spk_q;

endmodule

// File: rtl/attn_score_lif.sv
// Accumulates CHUNK_NUM partial Q.K popcount beats into one score per time step
// and runs a pipelined LIF neuron over the time steps. ATTN_SCORE_OUT_EN adds o_Attn_score.
module attn_score_lif
    import attn_score_lif_pkg::*;
#(
    parameter int unsigned CHUNK_NUM = 2,
    parameter int unsigned V_TH      = V_TH_DEFAULT
) (
    input logic              s_clk,
    input logic              s_rst,
    attn_score_lif_if.slave  bus
);

    localparam int unsigned ACC_W = acc_width(CHUNK_NUM);
    localparam int unsigned CNT_W = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNK_NUM - 1);

    typedef logic [TIME_STEPS-1:0][ACC_W-1:0] xvec_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_eff;
    xvec_t                 acc_q, acc_d, sum;
    xvec_t                 push_x_q, push_x_d;
    logic                  push_valid_q, push_valid_d;

    logic [TIME_STEPS:0]   stg_valid;
    logic [ACC_W-1:0]      stg_v   [TIME_STEPS+1];
    logic [TIME_STEPS-1:0] stg_spk [TIME_STEPS+1];

    logic                  attn_valid_q, attn_valid_d;
    logic [TIME_STEPS-1:0] attn_spikes_q, attn_spikes_d;
    logic                  busy_q, busy_d;

    // Chunk accumulation; a clear in the same cycle makes this beat chunk 0
    always_comb begin
        cnt_eff      = bus.i_Clear ? '0 : cnt_q;
        cnt_d        = cnt_eff;
        acc_d        = acc_q;
        push_valid_d = 1'b0;
        push_x_d     = push_x_q;
        for (int t = 0; t < int'(TIME_STEPS); t++) begin
            sum[t] = ((cnt_eff == '0) ? '0 : acc_q[t])
                   + ACC_W'(bus.i_Calc_data[SUM_W*t +: SUM_W]);
        end
        if (bus.i_Calc_valid) begin
            acc_d = sum;
            if (cnt_eff == CNT_LAST) begin
                push_valid_d = 1'b1;
                push_x_d     = sum;
                cnt_d        = '0;
            end else begin
                cnt_d = CNT_W'(cnt_eff + 1'b1);
            end
        end

        attn_valid_d  = stg_valid[TIME_STEPS];
        attn_spikes_d = stg_valid[TIME_STEPS] ? stg_spk[TIME_STEPS] : attn_spikes_q;
        busy_d        = (cnt_d != '0) | push_valid_d | (|stg_valid[TIME_STEPS-1:0]);
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            cnt_q         <= '0;
            acc_q         <= '0;
            push_x_q      <= '0;
            push_valid_q  <= 1'b0;
            attn_valid_q  <= 1'b0;
            attn_spikes_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            push_x_q      <= push_x_d;
            push_valid_q  <= push_valid_d;
            attn_valid_q  <= attn_valid_d;
            attn_spikes_q <= attn_spikes_d;
            busy_q        <= busy_d;
        end
    end

    assign stg_valid[0] = push_valid_q;
    assign stg_v[0]     = '0;
    assign stg_spk[0]   = '0;

    // Stage t sees X[t] delayed by t cycles so it lines up with its score
    for (genvar t = 0; t < TIME_STEPS; t++) begin : g_stage
        logic [ACC_W-1:0] x_t;

        if (t == 0) begin : g_now
            assign x_t = push_x_q[0];
        end else begin : g_dly
            logic [ACC_W-1:0] dly_q [t];
            logic [ACC_W-1:0] dly_d [t];

            always_comb begin
                dly_d[0] = push_x_q[t];
                for (int k = 1; k < t; k++) begin
                    dly_d[k] = dly_q[k-1];
                end
            end

            always_ff @(posedge s_clk) begin
                if (s_rst) dly_q <= '{default: '0};
                else       dly_q <= dly_d;
            end

            assign x_t = dly_q[t-1];
        end

        attn_score_lif_lif_step_stage #(
            .ACC_W      (ACC_W),
            .TIME_STEPS (TIME_STEPS),
            .STEP       (t),
            .V_TH       (V_TH)
        ) u_step (
            .s_clk      (s_clk),
            .s_rst      (s_rst),
            .in_valid   (stg_valid[t]),
            .in_v       (stg_v[t]),
            .in_x       (x_t),
            .in_spikes  (stg_spk[t]),
            .out_valid  (stg_valid[t+1]),
            .out_v      (stg_v[t+1]),
            .out_spikes (stg_spk[t+1])
        );
    end

    assign bus.o_Attn_valid  = attn_valid_q;
    assign bus.o_Attn_spikes = attn_spikes_q;
    assign bus.o_Busy        = busy_q;

`ifdef ATTN_SCORE_OUT_EN
    xvec_t sc_q [TIME_STEPS];
    xvec_t sc_d [TIME_STEPS];
    xvec_t score_q, score_d;

    // Raw sums ride a delay line matching the LIF pipeline depth
    always_comb begin
        sc_d[0] = push_x_q;
        for (int k = 1; k < int'(TIME_STEPS); k++) begin
            sc_d[k] = sc_q[k-1];
        end
        score_d = stg_valid[TIME_STEPS] ? sc_q[TIME_STEPS-1] : score_q;
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            sc_q    <= '{default: '0};
            score_q <= '0;
        end else begin
            sc_q    <= sc_d;
            score_q <= score_d;
        end
    end

    assign bus.o_Attn_score = score_q;
`endif

endmodule

// File: tb/tb_attn_score_lif.sv
// Directed bench for attn_score_lif: one CHUNK_NUM=2 instance and one CHUNK_NUM=1 instance.
module tb_attn_score_lif;

    logic s_clk;
    logic s_rst;
    int   checks;
    int   failures;

`ifdef ATTN_SCORE_OUT_EN
    attn_score_lif_if #(.ACC_W(7)) bus_a ();
    attn_score_lif_if #(.ACC_W(6)) bus_b ();
`else
    attn_score_lif_if bus_a ();
    attn_score_lif_if bus_b ();
`endif

    attn_score_lif #(.CHUNK_NUM(2)) dut_a (.s_clk(s_clk), .s_rst(s_rst), .bus(bus_a));
    attn_score_lif #(.CHUNK_NUM(1)) dut_b (.s_clk(s_clk), .s_rst(s_rst), .bus(bus_b));

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    // Reference LIF: tau=2, threshold 8, hard reset, V starts at 0
    function automatic logic [3:0] lif_pair(input logic [19:0] a, input logic [19:0] b);
        int v;
        int h;
        logic [3:0] s;
        v = 0;
        s = '0;
        for (int t = 0; t < 4; t++) begin
            h = (v + int'(a[5*t +: 5]) + int'(b[5*t +: 5])) / 2;
            if (h >= 8) begin
                s[t] = 1'b1;
                v    = 0;
            end else begin
                v = h;
            end
        end
        return s;
    endfunction

    task automatic drv_a(input logic v, input logic [19:0] d, input logic c);
        bus_a.i_Calc_valid = v;
        bus_a.i_Calc_data  = d;
        bus_a.i_Clear      = c;
        @(negedge s_clk);
    endtask

    task automatic drv_b(input logic v, input logic [19:0] d);
        bus_b.i_Calc_valid = v;
        bus_b.i_Calc_data  = d;
        bus_b.i_Clear      = 1'b0;
        @(negedge s_clk);
    endtask

    // Called right after the final beat: strobe must appear after exactly 5 edges
    task automatic expect_strobe_a(input string tag, input logic [3:0] exp_spk);
        for (int k = 1; k < 5; k++) begin
            drv_a(1'b0, '0, 1'b0);
            chk({tag, "_early_valid"}, 32'(bus_a.o_Attn_valid), 32'd0);
        end
        drv_a(1'b0, '0, 1'b0);
        chk({tag, "_valid"},  32'(bus_a.o_Attn_valid),  32'd1);
        chk({tag, "_spikes"}, 32'(bus_a.o_Attn_spikes), 32'(exp_spk));
        drv_a(1'b0, '0, 1'b0);
        chk({tag, "_strobe_end"}, 32'(bus_a.o_Attn_valid),  32'd0);
        chk({tag, "_hold"},       32'(bus_a.o_Attn_spikes), 32'(exp_spk));
    endtask

    logic [19:0] rnd_a [8];
    logic [19:0] rnd_b [20];
    logic        exp_v;

    initial begin
        checks   = 0;
        failures = 0;
        s_rst    = 1'b1;
        bus_a.i_Calc_valid = 1'b0; bus_a.i_Calc_data = '0; bus_a.i_Clear = 1'b0;
        bus_b.i_Calc_valid = 1'b0; bus_b.i_Calc_data = '0; bus_b.i_Clear = 1'b0;
        for (int i = 0; i < 8; i++)  rnd_a[i] = 20'($urandom);
        for (int i = 0; i < 20; i++) rnd_b[i] = 20'($urandom);
        rnd_b[3] = 20'hFFFFF;
        rnd_b[4] = 20'h00000;

        repeat (3) @(negedge s_clk);
        s_rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            drv_a(1'b0, '0, 1'b0);
            chk("idle_valid_a",  32'(bus_a.o_Attn_valid),  32'd0);
            chk("idle_spikes_a", 32'(bus_a.o_Attn_spikes), 32'd0);
            chk("idle_busy_a",   32'(bus_a.o_Busy),        32'd0);
            chk("idle_valid_b",  32'(bus_b.o_Attn_valid),  32'd0);
        end

        // X=(20,0,20,12) -> 0101
        drv_a(1'b1, pk(10, 0, 20, 6), 1'b0);
        chk("partial_busy", 32'(bus_a.o_Busy), 32'd1);
        drv_a(1'b1, pk(10, 0, 0, 6), 1'b0);
        expect_strobe_a("basic", 4'b0101);

        // Membrane carry: X=10 each -> H=5,7,8,5 -> 0100
        drv_a(1'b1, pk(5, 5, 5, 5), 1'b0);
        drv_a(1'b1, pk(5, 5, 5, 5), 1'b0);
        expect_strobe_a("carry", 4'b0100);

        // Full-scale sums: X=62 each -> 1111
        drv_a(1'b1, pk(31, 31, 31, 31), 1'b0);
        drv_a(1'b1, pk(31, 31, 31, 31), 1'b0);
        expect_strobe_a("extreme", 4'b1111);

        // 8 back-to-back beats -> 4 strobes 2 cycles apart
        for (int i = 0; i < 14; i++) begin
            if (i < 8) drv_a(1'b1, rnd_a[i], 1'b0);
            else       drv_a(1'b0, '0, 1'b0);
            exp_v = (i == 6) || (i == 8) || (i == 10) || (i == 12);
            chk("b2b_valid", 32'(bus_a.o_Attn_valid), 32'(exp_v));
            if (exp_v)
                chk("b2b_spikes", 32'(bus_a.o_Attn_spikes), 32'(lif_pair(rnd_a[i-6], rnd_a[i-5])));
            if (i == 11) chk("b2b_busy_tail", 32'(bus_a.o_Busy), 32'd1);
            if (i == 12) chk("b2b_busy_done", 32'(bus_a.o_Busy), 32'd0);
        end

        // Clear with beat: A discarded, score is C+D=(16,16,16,2) -> 0111
        drv_a(1'b1, pk(31, 31, 31, 31), 1'b0);
        drv_a(1'b1, pk(9, 4, 16, 0), 1'b1);
        drv_a(1'b1, pk(7, 12, 0, 2), 1'b0);
        expect_strobe_a("clear", 4'b0111);

        // Reset two cycles after a final beat drops the score
        drv_a(1'b1, pk(10, 0, 20, 6), 1'b0);
        drv_a(1'b1, pk(10, 0, 0, 6), 1'b0);
        drv_a(1'b0, '0, 1'b0);
        s_rst = 1'b1;
        drv_a(1'b0, '0, 1'b0);
        s_rst = 1'b0;
        chk("rst_spikes", 32'(bus_a.o_Attn_spikes), 32'd0);
        chk("rst_busy",   32'(bus_a.o_Busy),        32'd0);
        for (int i = 0; i < 8; i++) begin
            drv_a(1'b0, '0, 1'b0);
            chk("rst_no_strobe", 32'(bus_a.o_Attn_valid), 32'd0);
        end

        // CHUNK_NUM=1, continuous valid: output every cycle after a 5-cycle fill
        for (int i = 0; i < 25; i++) begin
            if (i < 20) drv_b(1'b1, rnd_b[i]);
            else        drv_b(1'b0, '0);
            if (i < 5) begin
                chk("c1_fill_valid", 32'(bus_b.o_Attn_valid), 32'd0);
            end else begin
                chk("c1_valid",  32'(bus_b.o_Attn_valid),  32'd1);
                chk("c1_spikes", 32'(bus_b.o_Attn_spikes), 32'(lif_pair(rnd_b[i-5], 20'd0)));
`ifdef ATTN_SCORE_OUT_EN
                chk("c1_score", 32'(bus_b.o_Attn_score),
                    32'({1'b0, rnd_b[i-5][19:15], 1'b0, rnd_b[i-5][14:10],
                         1'b0, rnd_b[i-5][9:5],   1'b0, rnd_b[i-5][4:0]}));
`endif
            end
        end
        drv_b(1'b0, '0);
        chk("c1_drain_valid", 32'(bus_b.o_Attn_valid), 32'd0);
        chk("c1_drain_busy",  32'(bus_b.o_Busy),       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/attn_score_lif.md
Name: attn_score_lif

Overview:
- Sits directly downstream of the attention-calculate PE.
- Consumes its per-time-step partial Q·K popcount sums, one beat per channel chunk.
- Accumulates CHUNK_NUM beats into one full attention score per time step, then runs a pipelined LIF neuron (tau=2, hard reset) across the time steps.
- Emits one attention spike vector per score, feeding the attention×V stage.

Parameters:
- TIME_STEPS, 4, spike time steps per beat; must equal the upstream value.
- SUM_W, 5, width of one per-time-step partial sum (upstream $clog2(2*SYSTOLIC_UNIT_NUM)).
- CHUNK_NUM, 2, beats accumulated per score; legal range 1..64.
- V_TH, 8, firing threshold in accumulated-sum units (0.125 scale folded in).
- ACC_W, SUM_W+$clog2(CHUNK_NUM+1), accumulator and membrane width; derived, not overridden.

Ports:
- s_clk  in  1  clock.
- s_rst  in  1  synchronous active-high reset.
- i_Calc_valid  in  1  partial-sum beat valid; no backpressure.
- i_Calc_data  in  SUM_W*TIME_STEPS  partial sums; slice t = [SUM_W*(t+1)-1 : SUM_W*t].
- i_Clear  in  1  restart chunk alignment.
- o_Attn_spikes  out  TIME_STEPS  bit t = spike at time step t.
- o_Attn_valid  out  1  one-cycle strobe per completed score.
- o_Busy  out  1  high while a partial score is held or the LIF pipeline is occupied.

Behaviour:
- Interface: one clock, s_clk; reset s_rst is synchronous, active-high.
- Reset: o_Attn_spikes=0, o_Attn_valid=0, o_Busy=0; chunk counter, accumulators, all pipeline valids and membranes cleared. Reset mid-operation drops in-flight scores; no output strobe follows.
- Accumulate stage:
  - chunk_cnt counts 0..CHUNK_NUM-1 on each i_Calc_valid.
  - acc[t] = (chunk_cnt==0 ? 0 : acc[t]) + slice t, zero-extended to ACC_W.
  - On the beat with chunk_cnt==CHUNK_NUM-1: push the final sums X[0..T-1] into LIF stage 0 with valid, wrap chunk_cnt to 0.
  - No valid: hold all state.
- Overflow: ACC_W is sized so CHUNK_NUM*(2^SUM_W-1) never wraps; no saturation logic.
- i_Clear: chunk_cnt forced to 0 and the partial score discarded.
  - Clear with valid in the same cycle: that beat is chunk 0 of a new score.
  - Clear does not touch scores already in the LIF pipeline.
- LIF pipeline: TIME_STEPS registered stages; stage t handles time step t, carrying V and spike bits forward.
  - V starts at 0 for each score.
  - H = (V + X[t]) >> 1, floor, unsigned, width ACC_W+1 before the shift.
  - spike[t] = (H >= V_TH); V_next = spike ? 0 : H.
- Latency: o_Attn_valid asserts exactly TIME_STEPS+1 cycles after the final-chunk beat is sampled.
- Throughput: one score per CHUNK_NUM valid beats; fully pipelined, so CHUNK_NUM=1 with continuous valid yields continuous output.
- Output hold: o_Attn_spikes holds its last value when o_Attn_valid=0.
- o_Busy = (chunk_cnt!=0) | any LIF stage valid.

Optional Feature:
- ATTN_SCORE_OUT_EN defined: adds output o_Attn_score [ACC_W*TIME_STEPS], the raw accumulated X[t] delayed alongside the pipeline. It is aligned with o_Attn_valid, resets to 0, and serves debug and softmax-free variants.
- Undefined: port and delay registers absent; spike behaviour identical.

Decomposition:
- Shared hyper-parameter include: TIME_STEPS, SYSTOLIC_UNIT_NUM, derived SUM_W, default V_TH.
- Sub-module lif_step_stage: one registered LIF time step (inputs V, X, valid, spike vector; outputs the next stage), instantiated TIME_STEPS times in a generate loop.

Test Plan:
- Reset, then idle -> o_Attn_valid=0, o_Attn_spikes=0, o_Busy=0 for 20 cycles.
- CHUNK_NUM=2, beats (t0..t3)=(10,0,20,6) then (10,0,0,6) -> X=(20,0,20,12); spikes 4'b0101; valid exactly 5 cycles after beat 2.
- Membrane carry: X=(10,10,10,10) split (5,5,5,5)+(5,5,5,5) -> H=5,7,8,5 -> spikes 4'b0100. Extreme: all slices 31 -> X=62, spikes 4'b1111.
- 8 back-to-back valid beats -> 4 strobes spaced 2 cycles apart, each matching the reference model; o_Busy low 5 cycles after the last beat.
- Beat A, then i_Clear with beat C, then beat D -> one strobe reflecting C+D only. Also assert s_rst 2 cycles after a final beat -> no strobe.
- CHUNK_NUM=1, continuous valid with random data -> output every cycle after a 5-cycle fill, bit-exact versus the model. With ATTN_SCORE_OUT_EN, o_Attn_score equals the input sums delayed 5 cycles.
